// File: rtl/rtc_bus_scheduler.sv
// Request-driven 37-cycle frame sequencer for a parallel RTC with a multiplexed AD bus.
// Define RTC_SCHED_INIT_EN to run one INIT_DATA -> INIT_ADDR write frame after every reset.
module rtc_bus_scheduler #(
    parameter logic [7:0] POLL_BASE   = 8'h21,
    parameter int         NUM_REGS    = 6,
    parameter int         REFRESH_DIV = 1000000,
    parameter logic [7:0] INIT_ADDR   = 8'h02,
    parameter logic [7:0] INIT_DATA   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       poll_en,
    output logic       rd_valid,
    output logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       ChipSelect,
    output logic       Read,
    output logic       Write,
    output logic       AoD,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);
    localparam int         TW      = $clog2(REFRESH_DIV);
    localparam int         IW      = $clog2(NUM_REGS + 1);
    localparam logic [5:0] FC_LAST = 6'd37;

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_INIT} state_t;
    typedef enum logic [1:0] {K_WRITE, K_READ, K_INIT} kind_t;

    state_t          state_reg, state_next;
    kind_t           kind_reg, kind_next;
    logic [5:0]      fc_reg, fc_next;
    logic [7:0]      addr_reg, addr_next;
    logic [7:0]      data_reg, data_next;
    logic [TW-1:0]   timer_reg;
    logic [IW-1:0]   poll_idx_reg;
    logic            poll_pending_reg;
    logic [7:0]      rd_addr_reg, rd_data_reg;

    logic frame_end, grant_slot, grant_init, grant_wr, grant_poll;
    logic poll_avail, timer_wrap, round_done;
    logic [7:0] poll_addr;

    assign frame_end  = (state_reg == S_FRAME) && (fc_reg == FC_LAST);
    assign grant_slot = (state_reg != S_FRAME) || frame_end;
    assign grant_init = grant_slot && (state_reg == S_INIT);
    // The write whose ack is being issued this cycle still has wr_req high; never re-grant it.
    assign grant_wr   = grant_slot && !grant_init && wr_req && !(frame_end && kind_reg == K_WRITE);
    // poll_idx counts granted frames, so reaching NUM_REGS blocks further grants until the last one ends.
    assign poll_avail = poll_pending_reg && poll_en && (poll_idx_reg < IW'(NUM_REGS));
    assign grant_poll = grant_slot && !grant_init && !grant_wr && poll_avail;
    assign timer_wrap = poll_en && (timer_reg == TW'(REFRESH_DIV - 1));
    assign round_done = frame_end && (kind_reg == K_READ) && (poll_idx_reg == IW'(NUM_REGS));
    assign poll_addr  = POLL_BASE + {{(8 - IW){1'b0}}, poll_idx_reg};

    always_comb begin
        state_next = state_reg;
        fc_next    = fc_reg;
        kind_next  = kind_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        if (grant_init) begin
            state_next = S_FRAME;
            fc_next    = 6'd1;
            kind_next  = K_INIT;
            addr_next  = INIT_ADDR;
            data_next  = INIT_DATA;
        end else if (grant_wr) begin
            state_next = S_FRAME;
            fc_next    = 6'd1;
            kind_next  = K_WRITE;
            addr_next  = wr_addr;
            data_next  = wr_data;
        end else if (grant_poll) begin
            state_next = S_FRAME;
            fc_next    = 6'd1;
            kind_next  = K_READ;
            addr_next  = poll_addr;
            data_next  = 8'h00;
        end else if (frame_end) begin
            state_next = S_IDLE;
            fc_next    = 6'd0;
        end else if (state_reg == S_FRAME) begin
            fc_next = fc_reg + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef RTC_SCHED_INIT_EN
            state_reg <= S_INIT;
`else
            state_reg <= S_IDLE;
`endif
            fc_reg           <= 6'd0;
            kind_reg         <= K_WRITE;
            addr_reg         <= 8'h00;
            data_reg         <= 8'h00;
            timer_reg        <= '0;
            poll_idx_reg     <= '0;
            poll_pending_reg <= 1'b0;
            rd_addr_reg      <= 8'h00;
            rd_data_reg      <= 8'h00;
        end else begin
            state_reg <= state_next;
            fc_reg    <= fc_next;
            kind_reg  <= kind_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;

            if (!poll_en || timer_wrap)
                timer_reg <= '0;
            else
                timer_reg <= timer_reg + 1'b1;

            // Ending a round wins over a coincident wrap, so that trigger is dropped.
            if (!poll_en || round_done) begin
                poll_pending_reg <= 1'b0;
                poll_idx_reg     <= '0;
            end else begin
                if (timer_wrap)
                    poll_pending_reg <= 1'b1;
                if (grant_poll)
                    poll_idx_reg <= poll_idx_reg + 1'b1;
            end

            if (state_reg == S_FRAME && kind_reg == K_READ && fc_reg == 6'd26) begin
                rd_addr_reg <= addr_reg;
                rd_data_reg <= ad_in;
            end
        end
    end

    assign rd_addr = rd_addr_reg;
    assign rd_data = rd_data_reg;

    always_comb begin
        ChipSelect = 1'b1;
        Read       = 1'b1;
        Write      = 1'b1;
        AoD        = 1'b1;
        ad_oe      = 1'b0;
        ad_out     = 8'h00;
        busy       = 1'b0;
        wr_ack     = 1'b0;
        rd_valid   = 1'b0;
        if (state_reg == S_FRAME) begin
            busy = 1'b1;
            if (fc_reg >= 6'd1 && fc_reg <= 6'd8) begin
                ChipSelect = 1'b0;
                AoD        = 1'b0;
                ad_oe      = 1'b1;
                ad_out     = addr_reg;
            end
            if (fc_reg >= 6'd2 && fc_reg <= 6'd7)
                Write = 1'b0;
            if (fc_reg >= 6'd20 && fc_reg <= 6'd27) begin
                ChipSelect = 1'b0;
                if (kind_reg != K_READ) begin
                    ad_oe  = 1'b1;
                    ad_out = data_reg;
                end
            end
            if (fc_reg >= 6'd21 && fc_reg <= 6'd26) begin
                if (kind_reg == K_READ)
                    Read = 1'b0;
                else
                    Write = 1'b0;
            end
            wr_ack   = (fc_reg == FC_LAST) && (kind_reg == K_WRITE);
            rd_valid = (fc_reg == 6'd27) && (kind_reg == K_READ);
        end
    end
endmodule
